issue_arbiter: RTL and testbench

Two-requester instruction issue arbiter placed in front of the pipelined microcontroller processor's instruction input. It lets two independent instruction sources share the single Decode port. Arbitration is round-robin, and the arbiter honours the processor's stall output. It records the owner of every issued instruction in an in-flight tag FIFO, so each processor output result is routed back to the requester that issued it.

---
 rtl/issue_arbiter.sv | 131 +++++++++++++
 tb/tb_issue_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/issue_arbiter.sv
// rtl/issue_arbiter.sv - two-requester round-robin issue arbiter with in-flight owner tags
module issue_arbiter #(
    parameter int INSTR_W   = 16,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           req0_valid,
    input  logic [INSTR_W-1:0]             req0_instr,
    output logic                           req0_ready,
    input  logic                           req1_valid,
    input  logic [INSTR_W-1:0]             req1_instr,
    output logic                           req1_ready,
    output logic                           proc_instr_valid,
    output logic [INSTR_W-1:0]             proc_instr,
    input  logic                           proc_stalled,
    input  logic                           proc_out_valid,
    input  logic [DATA_W-1:0]              proc_out_data,
    output logic                           rsp0_valid,
    output logic [DATA_W-1:0]              rsp0_data,
    output logic                           rsp1_valid,
    output logic [DATA_W-1:0]              rsp1_data,
    output logic [$clog2(TAG_DEPTH):0]     inflight,
    output logic                           err_orphan
);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic                 rr_q, rr_d;
    logic                 piv_q, piv_d;
    logic [INSTR_W-1:0]   pi_q, pi_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 rsp0v_q, rsp0v_d, rsp1v_q, rsp1v_d;
    logic [DATA_W-1:0]    rsp0d_q, rsp0d_d, rsp1d_q, rsp1d_d;
    logic                 err_q, err_d;

    logic can_issue, gnt_any, gnt_idx, pop, head;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        can_issue = (cnt_q < CW'(TAG_DEPTH)) && (!piv_q || !proc_stalled);
        gnt_any   = can_issue && (req0_valid || req1_valid);
        gnt_idx   = (req0_valid && req1_valid) ? ~rr_q : req1_valid;
        pop       = proc_out_valid && (cnt_q != '0);
        head      = tag_q[rd_q];
    end

    assign req0_ready = gnt_any && !gnt_idx;
    assign req1_ready = gnt_any && gnt_idx;

    always_comb begin
        rr_d    = rr_q;
        pi_d    = pi_q;
        piv_d   = piv_q && proc_stalled;
        tag_d   = tag_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        rsp0v_d = 1'b0;
        rsp1v_d = 1'b0;
        rsp0d_d = rsp0d_q;
        rsp1d_d = rsp1d_q;
        err_d   = err_q;

        if (gnt_any) begin
            rr_d         = gnt_idx;
            piv_d        = 1'b1;
            pi_d         = gnt_idx ? req1_instr : req0_instr;
            tag_d[wr_q]  = gnt_idx;
            wr_d         = wr_q + 1'b1;
        end

        if (pop) begin
            rd_d = rd_q + 1'b1;
            if (head) begin
                rsp1v_d = 1'b1;
                rsp1d_d = proc_out_data;
            end else begin
                rsp0v_d = 1'b1;
                rsp0d_d = proc_out_data;
            end
        end else if (proc_out_valid) begin
            err_d = 1'b1;
        end

        if (gnt_any && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!gnt_any && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q    <= 1'b1;
            piv_q   <= 1'b0;
            pi_q    <= '0;
            tag_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            rsp0v_q <= 1'b0;
            rsp1v_q <= 1'b0;
            rsp0d_q <= '0;
            rsp1d_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            piv_q   <= piv_d;
            pi_q    <= pi_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            rsp0v_q <= rsp0v_d;
            rsp1v_q <= rsp1v_d;
            rsp0d_q <= rsp0d_d;
            rsp1d_q <= rsp1d_d;
            err_q   <= err_d;
        end
    end

    assign proc_instr_valid = piv_q;
    assign proc_instr       = pi_q;
    assign rsp0_valid       = rsp0v_q;
    assign rsp1_valid       = rsp1v_q;
    assign rsp0_data        = rsp0d_q;
    assign rsp1_data        = rsp1d_q;
    assign inflight         = cnt_q;
    assign err_orphan       = err_q;
endmodule

// File: tb/tb_issue_arbiter.sv
// tb/tb_issue_arbiter.sv - randomized scoreboard bench for issue_arbiter
module tb_issue_arbiter;
    localparam int IW = 16;
    localparam int DW = 16;
    localparam int TD = 4;

    logic          clock, reset_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [IW-1:0] req0_instr, req1_instr, proc_instr;
    logic          proc_instr_valid, proc_stalled, proc_out_valid;
    logic [DW-1:0] proc_out_data, rsp0_data, rsp1_data;
    logic          rsp0_valid, rsp1_valid, err_orphan;
    logic [$clog2(TD):0] inflight;

    issue_arbiter #(.INSTR_W(IW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
        .proc_instr_valid(proc_instr_valid), .proc_instr(proc_instr),
        .proc_stalled(proc_stalled), .proc_out_valid(proc_out_valid),
        .proc_out_data(proc_out_data),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          r0, r1, piv, rv0, rv1, err;
        logic [IW-1:0] pi;
        logic [DW-1:0] rd0, rd1;
        int            infl;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: what the processor sees, who owns each in-flight result, what was last granted.
    bit          m_pv, m_rv0, m_rv1, m_err;
    logic [IW-1:0] m_pi;
    logic [DW-1:0] m_rd0, m_rd1;
    int          m_last;
    int          m_owner[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    exp_t mon_e;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            check("req0_ready", 32'(req0_ready), 32'(mon_e.r0));
            check("req1_ready", 32'(req1_ready), 32'(mon_e.r1));
            check("proc_instr_valid", 32'(proc_instr_valid), 32'(mon_e.piv));
            if (mon_e.piv) check("proc_instr", 32'(proc_instr), 32'(mon_e.pi));
            check("rsp0_valid", 32'(rsp0_valid), 32'(mon_e.rv0));
            check("rsp1_valid", 32'(rsp1_valid), 32'(mon_e.rv1));
            check("rsp0_data", 32'(rsp0_data), 32'(mon_e.rd0));
            check("rsp1_data", 32'(rsp1_data), 32'(mon_e.rd1));
            check("inflight", 32'(inflight), 32'(mon_e.infl));
            check("err_orphan", 32'(err_orphan), 32'(mon_e.err));
        end
    end

    task automatic model_reset();
        m_pv = 0; m_pi = '0; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
        m_err = 0; m_last = 1; m_owner.delete();
    endtask

    task automatic push_exp(input bit r0, input bit r1);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.piv = m_pv; e.pi = m_pi;
        e.rv0 = m_rv0; e.rv1 = m_rv1; e.rd0 = m_rd0; e.rd1 = m_rd1;
        e.infl = m_owner.size(); e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; proc_stalled = 0; proc_out_valid = 0;
        req0_instr = '0; req1_instr = '0; proc_out_data = '0;
    endtask

    task automatic step(input int p0, input int p1, input int pst, input int pov);
        int  g, t;
        bit  can;
        @(posedge clock); #1;
        req0_valid     = ($urandom_range(99) < p0);
        req1_valid     = ($urandom_range(99) < p1);
        proc_stalled   = ($urandom_range(99) < pst);
        proc_out_valid = ($urandom_range(99) < pov);
        req0_instr     = IW'($urandom);
        req1_instr     = IW'($urandom);
        proc_out_data  = DW'($urandom);

        can = (m_owner.size() < TD) && (!m_pv || !proc_stalled);
        g = -1;
        if (can) begin
            if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        push_exp(g == 0, g == 1);

        m_rv0 = 0; m_rv1 = 0;
        if (proc_out_valid) begin
            if (m_owner.size() > 0) begin
                t = m_owner.pop_front();
                if (t == 0) begin m_rv0 = 1; m_rd0 = proc_out_data; end
                else        begin m_rv1 = 1; m_rd1 = proc_out_data; end
            end else begin
                m_err = 1;
            end
        end
        if (g >= 0) begin
            m_owner.push_back(g);
            m_last = g;
            m_pv   = 1;
            m_pi   = (g == 1) ? req1_instr : req0_instr;
        end else if (!proc_stalled) begin
            m_pv = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset_n = 0;
        idle_inputs();
        model_reset();
        push_exp(0, 0);
        @(posedge clock); #1;
        reset_n = 1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        model_reset();
        #1;
        push_exp(0, 0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1;

        repeat (40) step(100, 100, 0, 60);
        do_reset();
        repeat (20) step(0, 100, 0, 30);
        repeat (40) step(70, 70, 60, 40);
        repeat (12) step(80, 80, 0, 0);
        repeat (20) step(60, 60, 20, 80);
        repeat (10) step(0, 0, 0, 100);
        repeat (5)  step(0, 0, 0, 0);
        repeat (3)  step(100, 0, 0, 0);
        do_reset();
        repeat (2)  step(100, 100, 0, 0);
        repeat (30) step(50, 50, 30, 50);
        for (int i = 0; i < 300; i++)
            step($urandom_range(100), $urandom_range(100), $urandom_range(70), $urandom_range(100));
        if ($urandom_range(1) == 1) do_reset();
        repeat (20) step(50, 50, 20, 50);

        @(negedge clock); @(negedge clock);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
